pipeline_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage MIPS pipeline (PC/IF/ID/EX/MEM/WB).
- Merges stall requests from ID (load-use), EX (multi-cycle ops) and MEM (memory wait) into one per-stage stall vector.
- Sequences exception and ERET flushes, and supplies the redirect PC.
- Tracks which in-flight instruction sits in a branch delay slot, so CP0 receives the correct EPC and BD bit.

---
 rtl/pipeline_ctrl_pkg.sv | 30 +++
 rtl/pipeline_ctrl_ds.sv | 48 ++++
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler.
// Stall bus layout, stall patterns, FSM encoding and the exception vector.
package pipeline_ctrl_pkg;

    localparam int ADDR_BUS   = 32;
    localparam int EXC_CODE_W = 5;
    localparam int STALL_BUS  = 6;

    // Stall bus bit positions, one per pipeline stage.
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // A request from stage N freezes stage N and everything upstream of it.
    localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_BUS-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_BUS-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_BUS-1:0] STALL_MEM  = 6'b011111;

    localparam logic [ADDR_BUS-1:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pipe_state_t;

endpackage

// File: rtl/pipeline_ctrl_ds.sv
// pipe_ds_tracker: follows the "is a branch delay slot" flag of each
// in-flight instruction from ID down to MEM, inserting 0 for bubbles.
module pipe_ds_tracker
    import pipeline_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_BUS-1:0] stall,
    input  logic                 flush,
    input  logic                 branch_flag_id,
    output logic                 ds_id,
    output logic                 ds_mem
);

    // ds_next is the flag that travels with the instruction entering ID, so
    // it is exactly the flag of whatever ID holds now.
    logic ds_next;
    logic ds_ex;
    logic ds_mem_q;

    // WB, IF and PC stall bits carry no delay-slot information.
    logic unused_stall;
    assign unused_stall = ^{stall[STG_WB], stall[STG_IF], stall[STG_PC]};

    // Shift the flags down the pipe; a stalled stage holds, the stage just
    // below a stalled one takes a bubble, a flush empties everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ds_next  <= 1'b0;
            ds_ex    <= 1'b0;
            ds_mem_q <= 1'b0;
        end else begin
            if (!stall[STG_ID]) begin
                ds_next <= branch_flag_id;
            end
            if (!stall[STG_EX]) begin
                ds_ex <= stall[STG_ID] ? 1'b0 : ds_next;
            end
            if (!stall[STG_MEM]) begin
                ds_mem_q <= stall[STG_EX] ? 1'b0 : ds_ex;
            end
        end
    end

    assign ds_id  = ds_next;
    assign ds_mem = ds_mem_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush scheduler for the 5-stage pipeline.
// Optional performance counters are built when PIPE_PERF_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal issue; an exception or ERET in MEM starts a flush
//   ST_FLUSH | single bubble cycle after a flush; exc/eret are ignored
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [ADDR_BUS-1:0] EXC_VECTOR     = EXC_VECTOR_DEFAULT,
    parameter int                  PERF_CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_req_id,
    input  logic                  stall_req_ex,
    input  logic                  stall_req_mem,
    input  logic                  branch_flag_id,
    input  logic                  exc_valid,
    input  logic [EXC_CODE_W-1:0] exc_code,
    input  logic [ADDR_BUS-1:0]   exc_pc,
    input  logic                  eret_valid,
    input  logic [ADDR_BUS-1:0]   cp0_epc,
    output logic [STALL_BUS-1:0]  stall,
    output logic                  flush,
    output logic [ADDR_BUS-1:0]   flush_pc,
    output logic                  id_in_delay_slot,
    output logic                  exc_commit,
    output logic [ADDR_BUS-1:0]   exc_epc,
    output logic                  exc_bd,
    output logic [EXC_CODE_W-1:0] exc_code_out
`ifdef PIPE_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] perf_stall_cycles,
    output logic [PERF_CNT_WIDTH-1:0] perf_flush_count
`endif
);

    pipe_state_t state;
    pipe_state_t next_state;
    logic        ds_id;
    logic        ds_mem;

    pipe_ds_tracker u_ds_tracker (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .branch_flag_id (branch_flag_id),
        .ds_id          (ds_id),
        .ds_mem         (ds_mem)
    );

    assign id_in_delay_slot = ds_id;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Flush sequencing, CP0 commit and stall encoding; all outputs are
    // forced quiet while reset is held.
    always_comb begin
        next_state   = state;
        stall        = STALL_NONE;
        flush        = 1'b0;
        flush_pc     = '0;
        exc_commit   = 1'b0;
        exc_epc      = '0;
        exc_bd       = 1'b0;
        exc_code_out = '0;
        if (!rst) begin
            unique case (state)
                ST_RUN: begin
                    if (exc_valid) begin
                        flush        = 1'b1;
                        flush_pc     = EXC_VECTOR;
                        exc_commit   = 1'b1;
                        exc_code_out = exc_code;
                        exc_bd       = ds_mem;
                        // A faulting delay slot reports the branch's PC.
                        exc_epc      = ds_mem ? (exc_pc - 32'd4) : exc_pc;
                        next_state   = ST_FLUSH;
                    end else if (eret_valid) begin
                        flush      = 1'b1;
                        flush_pc   = cp0_epc;
                        next_state = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    next_state = ST_RUN;
                end
                default: begin
                    next_state = ST_RUN;
                end
            endcase
            if (!flush) begin
                if (stall_req_mem) begin
                    stall = STALL_MEM;
                end else if (stall_req_ex) begin
                    stall = STALL_EX;
                end else if (stall_req_id) begin
                    stall = STALL_ID;
                end
            end
        end
    end

`ifdef PIPE_PERF_EN
    // Free-running stall-cycle and flush counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (stall != STALL_NONE) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
            if (flush) begin
                perf_flush_count <= perf_flush_count + 1'b1;
            end
        end
    end
`else
    localparam int unused_perf_cnt_width = PERF_CNT_WIDTH;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (define PIPE_PERF_EN to also cover
// the performance counters).
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req_id, stall_req_ex, stall_req_mem, branch_flag_id;
    logic        exc_valid, eret_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, cp0_epc;
    logic [5:0]  stall;
    logic        flush, id_in_delay_slot, exc_commit, exc_bd;
    logic [31:0] flush_pc, exc_epc;
    logic [4:0]  exc_code_out;
`ifdef PIPE_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit model_en = 1'b0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .stall_req_id     (stall_req_id),
        .stall_req_ex     (stall_req_ex),
        .stall_req_mem    (stall_req_mem),
        .branch_flag_id   (branch_flag_id),
        .exc_valid        (exc_valid),
        .exc_code         (exc_code),
        .exc_pc           (exc_pc),
        .eret_valid       (eret_valid),
        .cp0_epc          (cp0_epc),
        .stall            (stall),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .id_in_delay_slot (id_in_delay_slot),
        .exc_commit       (exc_commit),
        .exc_epc          (exc_epc),
        .exc_bd           (exc_bd),
        .exc_code_out     (exc_code_out)
`ifdef PIPE_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_count (perf_flush_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a flush happens when MEM reports exc/eret and the
    // previous cycle was not itself a flush; a stall request freezes its
    // stage and all upstream stages; delay-slot flags ride with instructions.
    bit          m_prev_flush = 1'b0;
    bit          m_ds [0:5];
    logic [31:0] m_stall_cnt = 0;
    logic [31:0] m_flush_cnt = 0;

    initial for (int k = 0; k < 6; k++) m_ds[k] = 1'b0;

    always @(negedge clk) begin
        logic [5:0]  e_stall;
        logic        e_flush, e_commit, e_bd;
        logic [31:0] e_pc, e_epc;
        logic [4:0]  e_code;
        int          depth;
        e_stall = 0; e_flush = 0; e_commit = 0; e_bd = 0;
        e_pc = 0; e_epc = 0; e_code = 0; depth = 0;
        if (!rst) begin
            if (!m_prev_flush && exc_valid) begin
                e_flush  = 1;
                e_pc     = 32'hBFC00380;
                e_commit = 1;
                e_bd     = m_ds[4];
                e_epc    = m_ds[4] ? exc_pc - 32'd4 : exc_pc;
                e_code   = exc_code;
            end else if (!m_prev_flush && eret_valid) begin
                e_flush = 1;
                e_pc    = cp0_epc;
            end
            depth = stall_req_mem ? 5 : stall_req_ex ? 4 : stall_req_id ? 3 : 0;
            if (!e_flush) e_stall = 6'((1 << depth) - 1);
        end
        if (model_en) begin
            chk("m_stall", {26'd0, stall}, {26'd0, e_stall});
            chk("m_flush", {31'd0, flush}, {31'd0, e_flush});
            chk("m_flush_pc", flush_pc, e_pc);
            chk("m_commit", {31'd0, exc_commit}, {31'd0, e_commit});
            chk("m_epc", exc_epc, e_epc);
            chk("m_bd", {31'd0, exc_bd}, {31'd0, e_bd});
            chk("m_code", {27'd0, exc_code_out}, {27'd0, e_code});
            chk("m_id_ds", {31'd0, id_in_delay_slot}, {31'd0, m_ds[2]});
`ifdef PIPE_PERF_EN
            chk("m_perf_stall", perf_stall_cycles, m_stall_cnt);
            chk("m_perf_flush", perf_flush_count, m_flush_cnt);
`endif
        end
        // Advance the model to the state after the coming clock edge.
        if (rst) begin
            for (int k = 0; k < 6; k++) m_ds[k] = 1'b0;
            m_prev_flush = 1'b0;
            m_stall_cnt  = 0;
            m_flush_cnt  = 0;
        end else begin
            if (e_stall != 0) m_stall_cnt = m_stall_cnt + 1;
            if (e_flush) m_flush_cnt = m_flush_cnt + 1;
            if (e_flush) begin
                for (int k = 0; k < 6; k++) m_ds[k] = 1'b0;
            end else begin
                for (int k = 4; k >= 3; k--)
                    if (!e_stall[k]) m_ds[k] = e_stall[k-1] ? 1'b0 : m_ds[k-1];
                if (!e_stall[2]) m_ds[2] = branch_flag_id;
            end
            m_prev_flush = e_flush;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_req_id = 0; stall_req_ex = 0; stall_req_mem = 0; branch_flag_id = 0;
        exc_valid = 0; eret_valid = 0; exc_code = 0; exc_pc = 0; cp0_epc = 0;
    endtask

    // {stall_req_id, stall_req_ex, stall_req_mem, branch_flag_id, exc_valid, eret_valid}
    localparam int NVEC = 14;
    logic [5:0] vec [NVEC] = '{
        6'b000100, 6'b100100, 6'b100000, 6'b000000, 6'b000100, 6'b010000,
        6'b000000, 6'b001000, 6'b000100, 6'b001000, 6'b000000, 6'b000000,
        6'b000010, 6'b000000
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        next_cyc();
        model_en = 1;
        @(negedge clk);
        chk("rst_stall", {26'd0, stall}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_id_ds", {31'd0, id_in_delay_slot}, 32'd0);

        next_cyc(); rst = 0; stall_req_id = 1;
        @(negedge clk); chk("stall_id", {26'd0, stall}, 32'b000111);
        next_cyc(); stall_req_mem = 1;
        @(negedge clk); chk("stall_mem", {26'd0, stall}, 32'b011111);
        next_cyc(); idle();
        @(negedge clk); chk("stall_none", {26'd0, stall}, 32'd0);

        next_cyc(); branch_flag_id = 1;
        next_cyc(); branch_flag_id = 0;
        @(negedge clk); chk("ds_id_after_branch", {31'd0, id_in_delay_slot}, 32'd1);
        next_cyc();
        next_cyc(); exc_valid = 1; exc_pc = 32'h80000014; exc_code = 5'h04;
        @(negedge clk);
        chk("ds_exc_bd", {31'd0, exc_bd}, 32'd1);
        chk("ds_exc_epc", exc_epc, 32'h80000010);
        chk("ds_flush_pc", flush_pc, 32'hBFC00380);
        chk("ds_commit", {31'd0, exc_commit}, 32'd1);
        next_cyc(); idle();
        @(negedge clk); chk("ds_commit_drop", {31'd0, exc_commit}, 32'd0);

        next_cyc(); exc_valid = 1; exc_pc = 32'h80000020; exc_code = 5'h0C;
        @(negedge clk);
        chk("nods_epc", exc_epc, 32'h80000020);
        chk("nods_bd", {31'd0, exc_bd}, 32'd0);
        chk("nods_code", {27'd0, exc_code_out}, 32'h0C);
        next_cyc(); idle();

        next_cyc(); eret_valid = 1; cp0_epc = 32'h80001000;
        @(negedge clk);
        chk("eret_flush", {31'd0, flush}, 32'd1);
        chk("eret_pc", flush_pc, 32'h80001000);
        chk("eret_commit", {31'd0, exc_commit}, 32'd0);
        next_cyc(); idle(); exc_valid = 1; exc_pc = 32'h80000040;
        @(negedge clk);
        chk("post_eret_exc_ignored", {31'd0, flush}, 32'd0);
        chk("post_eret_commit", {31'd0, exc_commit}, 32'd0);
        next_cyc(); idle();

        next_cyc(); exc_valid = 1; stall_req_mem = 1; exc_pc = 32'h80000100;
        @(negedge clk);
        chk("exc_over_stall_flush", {31'd0, flush}, 32'd1);
        chk("exc_over_stall_stall", {26'd0, stall}, 32'd0);
        next_cyc();
        @(negedge clk);
        chk("b2b_commit", {31'd0, exc_commit}, 32'd0);
        chk("flush_cycle_stall", {26'd0, stall}, 32'b011111);
        next_cyc(); idle();

        for (int i = 0; i < NVEC; i++) begin
            next_cyc();
            {stall_req_id, stall_req_ex, stall_req_mem, branch_flag_id, exc_valid, eret_valid} = vec[i];
            exc_pc = 32'h80000200 + 32'(i * 4);
            exc_code = 5'h0A;
        end
        next_cyc(); idle();

        next_cyc(); exc_valid = 1; exc_pc = 32'h80000300;
        next_cyc(); idle(); rst = 1;
        @(negedge clk);
        chk("rst_in_flush_flush", {31'd0, flush}, 32'd0);
        next_cyc(); rst = 0;
        @(negedge clk);
        chk("after_rst_stall", {26'd0, stall}, 32'd0);
        chk("after_rst_commit", {31'd0, exc_commit}, 32'd0);
        next_cyc(); eret_valid = 1; cp0_epc = 32'h80002000;
        @(negedge clk); chk("after_rst_run", {31'd0, flush}, 32'd1);
        next_cyc(); idle();

`ifdef PIPE_PERF_EN
        next_cyc(); rst = 1;
        next_cyc(); rst = 0; stall_req_ex = 1;
        next_cyc();
        next_cyc();
        next_cyc(); idle(); eret_valid = 1; cp0_epc = 32'h80003000;
        next_cyc(); idle();
        @(negedge clk);
        chk("perf_stall_cycles", perf_stall_cycles, 32'd3);
        chk("perf_flush_count", perf_flush_count, 32'd1);
`endif

        next_cyc();
        next_cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
